// File: rtl/cle_label_stats.sv
// cle_label_stats: raster-scans the 32x32 label image and builds per-label pixel count + bounding box, then streams one record per label.
// Latency: 1024 read cycles + 1 drain cycle; first record 1026 cycles after start, then one record per accepted handshake.
// Backpressure: res_* held stable while res_valid_o && !res_ready_i; the SRAM scan itself never stalls.
//
// Ports:
//   clk_i, reset_i (sync, active-high)     start_i : begin scan (only honoured in IDLE)
//   sram_a_o / sram_q_i                     : read-only SRAM port, data returns one cycle after address
//   busy_o, done_o                          : operation in progress / one-cycle end pulse
//   res_valid_o/res_ready_i + res_*         : per-label record stream in allocation order
//   num_labels_o, overflow_o                : table fill and table-full drop indication of last scan
module cle_label_stats #(
    parameter int MAX_LABELS = 8
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        start_i,
    output logic [9:0]  sram_a_o,
    input  logic [7:0]  sram_q_i,
    output logic        busy_o,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [7:0]  res_label_o,
    output logic [10:0] res_count_o,
    output logic [4:0]  res_rmin_o,
    output logic [4:0]  res_rmax_o,
    output logic [4:0]  res_cmin_o,
    output logic [4:0]  res_cmax_o,
    output logic [3:0]  num_labels_o,
    output logic        overflow_o,
    output logic        done_o
);

    localparam int         AW    = $clog2(MAX_LABELS);
    localparam logic [3:0] MAX_N = 4'(MAX_LABELS);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, EMIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [9:0]    addr_q, addr_d;
    logic [AW-1:0] idx_q, idx_d;

    // Address delayed by one cycle so row/col line up with the returning data word.
    logic          pix_vld_q;
    logic [4:0]    pix_row_q;
    logic [4:0]    pix_col_q;

    logic [7:0]    lbl_q  [MAX_LABELS];
    logic [10:0]   cnt_q  [MAX_LABELS];
    logic [4:0]    rmin_q [MAX_LABELS];
    logic [4:0]    rmax_q [MAX_LABELS];
    logic [4:0]    cmin_q [MAX_LABELS];
    logic [4:0]    cmax_q [MAX_LABELS];
    logic [3:0]    num_q, num_d;
    logic          ovf_q;

    logic          clr;
    logic          pix_act;
    logic          hit;
    logic          full;
    logic          do_upd;
    logic          do_alloc;
    logic          do_ovf;
    logic          emit_hs;
    logic          emit_last;
    logic [AW-1:0] hit_idx;
    logic [AW-1:0] alloc_idx;

    // Only entries below num_q are live; cleared entries hold label 0, which
    // never reaches the match because background pixels are filtered first.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < MAX_LABELS; i++) begin
            if ((4'(i) < num_q) && (lbl_q[i] == sram_q_i)) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    assign clr       = (state_q == IDLE) && start_i;
    assign full      = (num_q == MAX_N);
    assign pix_act   = pix_vld_q && (sram_q_i != 8'd0);
    assign do_upd    = pix_act && hit;
    assign do_alloc  = pix_act && !hit && !full;
    assign do_ovf    = pix_act && !hit && full;
    assign alloc_idx = num_q[AW-1:0];
    assign num_d     = num_q + {3'b000, do_alloc};
    assign emit_hs   = (state_q == EMIT) && res_ready_i;
    assign emit_last = (4'(idx_q) == (num_q - 4'd1));

    always_comb begin
        state_d = state_q;
        addr_d  = '0;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (addr_q == 10'd1023) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 10'd1;
                end
            end
            // Decision uses num_d so a label first seen at address 1023 is emitted.
            DRAIN:   state_d = (num_d != 4'd0) ? EMIT : DONE;
            EMIT: begin
                if (emit_hs) begin
                    if (emit_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            idx_q     <= '0;
            pix_vld_q <= 1'b0;
            pix_row_q <= '0;
            pix_col_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            pix_vld_q <= (state_q == SCAN);
            pix_row_q <= addr_q[9:5];
            pix_col_q <= addr_q[4:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clr) begin
            for (int i = 0; i < MAX_LABELS; i++) begin
                lbl_q[i]  <= '0;
                cnt_q[i]  <= '0;
                rmin_q[i] <= '0;
                rmax_q[i] <= '0;
                cmin_q[i] <= '0;
                cmax_q[i] <= '0;
            end
            num_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_upd) begin
                // Max count is 1024, which fits 11 bits without wrapping.
                cnt_q[hit_idx] <= cnt_q[hit_idx] + 11'd1;
                if (pix_row_q < rmin_q[hit_idx]) rmin_q[hit_idx] <= pix_row_q;
                if (pix_row_q > rmax_q[hit_idx]) rmax_q[hit_idx] <= pix_row_q;
                if (pix_col_q < cmin_q[hit_idx]) cmin_q[hit_idx] <= pix_col_q;
                if (pix_col_q > cmax_q[hit_idx]) cmax_q[hit_idx] <= pix_col_q;
            end
            if (do_alloc) begin
                lbl_q[alloc_idx]  <= sram_q_i;
                cnt_q[alloc_idx]  <= 11'd1;
                rmin_q[alloc_idx] <= pix_row_q;
                rmax_q[alloc_idx] <= pix_row_q;
                cmin_q[alloc_idx] <= pix_col_q;
                cmax_q[alloc_idx] <= pix_col_q;
            end
            if (do_ovf) begin
                ovf_q <= 1'b1;
            end
            num_q <= num_d;
        end
    end

    assign sram_a_o     = addr_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign res_valid_o  = (state_q == EMIT);
    assign num_labels_o = num_q;
    assign overflow_o   = ovf_q;

    // Record fields are a register-only mux, zeroed outside EMIT.
    assign res_label_o  = res_valid_o ? lbl_q[idx_q]  : '0;
    assign res_count_o  = res_valid_o ? cnt_q[idx_q]  : '0;
    assign res_rmin_o   = res_valid_o ? rmin_q[idx_q] : '0;
    assign res_rmax_o   = res_valid_o ? rmax_q[idx_q] : '0;
    assign res_cmin_o   = res_valid_o ? cmin_q[idx_q] : '0;
    assign res_cmax_o   = res_valid_o ? cmax_q[idx_q] : '0;

endmodule

// File: tb/tb_cle_label_stats.sv
// tb_cle_label_stats: drives label images through cle_label_stats and checks every cycle against a list-based reference.
// Latency: n/a (bench).
// Backpressure: res_ready driven always-on, in a fixed 1,0,0,1 pattern, or randomly.
module tb_cle_label_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  sram_a;
    logic [7:0]  sram_q = 8'd0;
    logic        busy;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_label;
    logic [10:0] res_count;
    logic [4:0]  res_rmin, res_rmax, res_cmin, res_cmax;
    logic [3:0]  num_labels;
    logic        overflow;
    logic        done;

    always #5 clk = ~clk;

    cle_label_stats #(.MAX_LABELS(8)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .start_i      (start),
        .sram_a_o     (sram_a),
        .sram_q_i     (sram_q),
        .busy_o       (busy),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_label_o  (res_label),
        .res_count_o  (res_count),
        .res_rmin_o   (res_rmin),
        .res_rmax_o   (res_rmax),
        .res_cmin_o   (res_cmin),
        .res_cmax_o   (res_cmax),
        .num_labels_o (num_labels),
        .overflow_o   (overflow),
        .done_o       (done)
    );

    // Synchronous-read SRAM: data for the address seen at an edge appears after it.
    logic [7:0] mem [1024];
    always @(posedge clk) sram_q <= mem[sram_a];

    typedef struct {
        int lbl;
        int cnt;
        int rmin;
        int rmax;
        int cmin;
        int cmax;
    } rec_t;

    rec_t exp_q[$];
    int   exp_ovf;
    int   total = 0;
    int   bad   = 0;

    int cap_done_c, cap_num, cap_ovf;
    int cap_lbl0, cap_cnt0, cap_rmin0, cap_rmax0, cap_cmin0, cap_cmax0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
    endtask

    // Reference: walk the image in raster order keeping a first-seen-ordered list.
    task automatic build_model();
        int v, r, c, f;
        rec_t t;
        exp_q.delete();
        exp_ovf = 0;
        for (int a = 0; a < 1024; a++) begin
            v = int'(mem[a]);
            r = a / 32;
            c = a % 32;
            f = -1;
            if (v != 0) begin
                for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].lbl == v) f = i;
                if (f >= 0) begin
                    exp_q[f].cnt = exp_q[f].cnt + 1;
                    if (r < exp_q[f].rmin) exp_q[f].rmin = r;
                    if (r > exp_q[f].rmax) exp_q[f].rmax = r;
                    if (c < exp_q[f].cmin) exp_q[f].cmin = c;
                    if (c > exp_q[f].cmax) exp_q[f].cmax = c;
                end else if (exp_q.size() < 8) begin
                    t.lbl = v; t.cnt = 1; t.rmin = r; t.rmax = r; t.cmin = c; t.cmax = c;
                    exp_q.push_back(t);
                end else begin
                    exp_ovf = 1;
                end
            end
        end
    endtask

    // One start-to-idle operation; c counts cycles after the edge that samples start.
    task automatic run(input int rmode, input int reset_at, input int mid_start_at);
        int n, r, e;
        bit rdy, fin;
        build_model();
        n = exp_q.size();
        r = 0;
        fin = 1'b0;
        cap_done_c = -1; cap_num = -1; cap_ovf = -1;
        cap_lbl0 = -1; cap_cnt0 = -1; cap_rmin0 = -1; cap_rmax0 = -1; cap_cmin0 = -1; cap_cmax0 = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 4000 && !fin; c++) begin
            if (reset_at > 0 && c == reset_at + 1) begin
                chk("rst_busy", busy, 0);
                chk("rst_valid", res_valid, 0);
                chk("rst_done", done, 0);
                chk("rst_addr", sram_a, 0);
                chk("rst_num", num_labels, 0);
                chk("rst_ovf", overflow, 0);
                reset = 1'b0;
                fin = 1'b1;
            end else if (c <= 1025) begin
                chk("scan_busy", busy, 1);
                chk("scan_valid", res_valid, 0);
                chk("scan_done", done, 0);
                if (c <= 1024) chk("scan_addr", sram_a, c - 1);
                if (c == 1) begin
                    chk("start_num_clr", num_labels, 0);
                    chk("start_ovf_clr", overflow, 0);
                end
            end else if (r < n) begin
                chk("emit_valid", res_valid, 1);
                chk("emit_done", done, 0);
                chk("emit_busy", busy, 1);
                chk("rec_label", res_label, exp_q[r].lbl);
                chk("rec_count", res_count, exp_q[r].cnt);
                chk("rec_rmin", res_rmin, exp_q[r].rmin);
                chk("rec_rmax", res_rmax, exp_q[r].rmax);
                chk("rec_cmin", res_cmin, exp_q[r].cmin);
                chk("rec_cmax", res_cmax, exp_q[r].cmax);
                if (r == 0 && c == 1026) begin
                    cap_lbl0 = int'(res_label); cap_cnt0 = int'(res_count);
                    cap_rmin0 = int'(res_rmin); cap_rmax0 = int'(res_rmax);
                    cap_cmin0 = int'(res_cmin); cap_cmax0 = int'(res_cmax);
                end
            end else if (cap_done_c < 0) begin
                chk("done_pulse", done, 1);
                chk("done_valid", res_valid, 0);
                chk("done_busy", busy, 1);
                chk("done_num", num_labels, n);
                chk("done_ovf", overflow, exp_ovf);
                cap_done_c = c;
                cap_num = int'(num_labels);
                cap_ovf = int'(overflow);
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_valid", res_valid, 0);
                chk("idle_num", num_labels, n);
                chk("idle_ovf", overflow, exp_ovf);
                fin = 1'b1;
            end
            e = c - 1026;
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (e % 4 == 0) || (e % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            res_ready = rdy;
            start = (c == mid_start_at);
            if (reset_at > 0 && c == reset_at) reset = 1'b1;
            if (c >= 1026 && r < n && rdy) r++;
            if (!fin) @(negedge clk);
        end
        start = 1'b0;
        if (!fin) chk("timeout", 0, 1);
    endtask

    task automatic img_two_labels();
        clear_mem();
        for (int r = 2; r <= 4; r++)
            for (int c = 10; c <= 12; c++) mem[r * 32 + c] = 8'h03;
        for (int c = 0; c < 32; c++) mem[31 * 32 + c] = 8'h01;
    endtask

    initial begin
        logic [7:0] pal [12];
        int np;
        reset = 1'b1;
        start = 1'b0;
        res_ready = 1'b0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("reset_addr", sram_a, 0);
        chk("reset_busy", busy, 0);
        chk("reset_valid", res_valid, 0);
        chk("reset_label", res_label, 0);
        chk("reset_count", res_count, 0);
        chk("reset_box", {res_rmin, res_rmax, res_cmin, res_cmax}, 0);
        chk("reset_num", num_labels, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;

        // All background.
        clear_mem();
        run(0, 0, 0);
        chk("t1_done_cycle", cap_done_c, 1026);
        chk("t1_num", cap_num, 0);
        chk("t1_ovf", cap_ovf, 0);

        // Single pixel at row 1, col 1.
        clear_mem();
        mem[33] = 8'h05;
        run(0, 0, 0);
        chk("t2_label", cap_lbl0, 5);
        chk("t2_count", cap_cnt0, 1);
        chk("t2_box", {cap_rmin0[7:0], cap_rmax0[7:0], cap_cmin0[7:0], cap_cmax0[7:0]}, 32'h01010101);
        chk("t2_done_cycle", cap_done_c, 1027);

        // Block plus full bottom row.
        img_two_labels();
        run(0, 0, 0);
        chk("t3_label0", cap_lbl0, 3);
        chk("t3_count0", cap_cnt0, 9);
        chk("t3_box0", {cap_rmin0[7:0], cap_rmax0[7:0], cap_cmin0[7:0], cap_cmax0[7:0]}, 32'h02040A0C);
        chk("t3_done_cycle", cap_done_c, 1028);
        chk("t3_num", cap_num, 2);

        // Nine distinct labels: ninth is dropped.
        clear_mem();
        for (int a = 0; a < 9; a++) mem[a] = 8'(a + 1);
        run(0, 0, 0);
        chk("t4_num", cap_num, 8);
        chk("t4_ovf", cap_ovf, 1);
        chk("t4_done_cycle", cap_done_c, 1034);

        // Stalled consumer: handshakes land at cycles 1026 and 1029.
        img_two_labels();
        run(1, 0, 0);
        chk("t5_done_cycle", cap_done_c, 1030);

        // Reset at address 500 with a redundant start mid-scan, then a clean rescan.
        clear_mem();
        mem[700] = 8'h44;
        run(0, 501, 300);
        img_two_labels();
        run(0, 0, 300);
        chk("t6_num", cap_num, 2);
        chk("t6_label0", cap_lbl0, 3);

        // One label covering the whole image: count must reach 1024.
        for (int a = 0; a < 1024; a++) mem[a] = 8'h07;
        run(0, 0, 0);
        chk("t7_count", cap_cnt0, 1024);
        chk("t7_box", {cap_rmin0[7:0], cap_rmax0[7:0], cap_cmin0[7:0], cap_cmax0[7:0]}, 32'h001F001F);
        chk("t7_done_cycle", cap_done_c, 1027);

        // Random images with random backpressure.
        for (int it = 0; it < 4; it++) begin
            np = $urandom_range(3, 12);
            for (int j = 0; j < 12; j++) pal[j] = 8'($urandom_range(1, 255));
            for (int a = 0; a < 1024; a++)
                mem[a] = ($urandom_range(0, 9) < 3) ? pal[$urandom_range(0, np - 1)] : 8'd0;
            run(2, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
